// File: rtl/pixel_mm_writer_if.sv
// pixel_mm_writer_if: RGB565 pixel stream in, Avalon-MM word-write bus out
interface pixel_mm_writer_if #(parameter int ADDR_W = 13);
  logic [15:0] pix_data;
  logic pix_valid;
  logic pix_last;
  logic pix_ready;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0] avm_byteenable;
  logic avm_chipselect;
  logic avm_write;
  logic [31:0] avm_writedata;
  logic avm_waitrequest;
  modport master(
    input pix_data, pix_valid, pix_last, avm_waitrequest,
    output pix_ready, avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata
  );
  modport slave(
    output pix_data, pix_valid, pix_last, avm_waitrequest,
    input pix_ready, avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata
  );
endinterface

// File: rtl/pixel_mm_writer.sv
// pixel_mm_writer: packs pixel pairs into 32-bit words and writes a frame to Avalon-MM memory
module pixel_mm_writer #(
  parameter int ADDR_W = 13,
  parameter int NUM_WORDS = 8192
) (
  input logic clk,
  input logic reset,
  input logic start,
  pixel_mm_writer_if.master bus,
  output logic busy,
  output logic done,
  output logic overflow,
  output logic [ADDR_W:0] word_count
);
  typedef enum logic [2:0] {IDLE, LO, HI, WR, FIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [31:0] data;
  logic [3:0] be;
  logic last;
  logic xfer, cmpl, at_end;
  assign xfer = bus.pix_valid && bus.pix_ready;
  assign cmpl = state == WR && !bus.avm_waitrequest;
  assign at_end = addr == ADDR_W'(NUM_WORDS - 1);
  assign bus.avm_address = addr;
  assign bus.avm_writedata = data;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? LO : IDLE;
      LO: state_n = xfer ? (bus.pix_last ? WR : HI) : LO;
      HI: state_n = xfer ? WR : HI;
      WR: state_n = cmpl ? (last ? FIN : LO) : WR;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.pix_ready = state == LO || state == HI;
    bus.avm_write = state == WR;
    bus.avm_chipselect = state == WR;
    bus.avm_byteenable = state == WR ? be : 4'h0;
    busy = state != IDLE;
    done = state == FIN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr <= '0;
      data <= '0;
      be <= '0;
      last <= 1'b0;
      word_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr <= '0;
        word_count <= '0;
        overflow <= 1'b0;
      end
      if (xfer && state == LO) begin
        data[15:0] <= bus.pix_data;
        be <= 4'b0011;
      end
      if (xfer && state == HI) begin
        data[31:16] <= bus.pix_data;
        be <= 4'b1111;
      end
      if (xfer) last <= bus.pix_last;
      // the buffer is circular: the word after NUM_WORDS-1 lands at 0
      if (cmpl) begin
        addr <= at_end ? '0 : addr + ADDR_W'(1);
        word_count <= word_count == (ADDR_W+1)'(NUM_WORDS) ? word_count : word_count + (ADDR_W+1)'(1);
        if (at_end && !last) overflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pixel_mm_writer.sv
// tb_pixel_mm_writer: directed and random frames checked against a word-queue model
module tb_pixel_mm_writer;
  localparam int AW = 3;
  localparam int NW = 4;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0] be;
    logic last;
  } wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, overflow;
  logic [AW:0] word_count;
  int total = 0;
  int passed = 0;
  logic wr_rand = 1'b0;
  wr_t expq[$];
  wr_t wlog[$];
  wr_t w, a;
  logic m_busy = 1'b0, m_fin = 1'b0, m_ended = 1'b0, m_ovf = 1'b0, have_lo = 1'b0;
  logic exp_ready, w_start;
  int m_addr = 0, m_wc = 0;
  logic [15:0] lo_pix = '0;
  logic [31:0] mask;
  pixel_mm_writer_if #(.ADDR_W(AW)) bus();
  pixel_mm_writer #(.ADDR_W(AW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.master),
    .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  function automatic wr_t log_at(input int i);
    return i < wlog.size() ? wlog[i] : '0;
  endfunction
  task automatic push_word(input logic [31:0] d, input logic [3:0] b, input logic l);
    wr_t t;
    t.addr = AW'(m_addr);
    t.data = d;
    t.be = b;
    t.last = l;
    expq.push_back(t);
    m_addr = (m_addr + 1) % NW;
  endtask
  // model: compare current outputs, then advance over the coming edge
  initial forever begin
    @(negedge clk);
    if (reset) begin
      expq.delete();
      {m_busy, m_fin, m_ended, m_ovf, have_lo} = '0;
      m_addr = 0;
      m_wc = 0;
    end
    exp_ready = m_busy && !m_ended && expq.size() == 0;
    chk("pix_ready", 32'(bus.pix_ready), 32'(exp_ready));
    chk("avm_write", 32'(bus.avm_write), 32'(expq.size() != 0));
    chk("avm_chipselect", 32'(bus.avm_chipselect), 32'(expq.size() != 0));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_fin));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("word_count", 32'(word_count), 32'(m_wc));
    if (expq.size() != 0) begin
      for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{expq[0].be[i]}};
      chk("avm_address", 32'(bus.avm_address), 32'(expq[0].addr));
      chk("avm_byteenable", 32'(bus.avm_byteenable), 32'(expq[0].be));
      chk("avm_writedata", bus.avm_writedata & mask, expq[0].data & mask);
    end else chk("byteenable_idle", 32'(bus.avm_byteenable), 32'h0);
    if (!reset) begin
      w_start = start && !m_busy;
      if (m_fin) begin
        m_fin = 1'b0;
        m_busy = 1'b0;
      end
      if (expq.size() != 0 && !bus.avm_waitrequest) begin
        w = expq.pop_front();
        a.addr = bus.avm_address;
        a.data = bus.avm_writedata;
        a.be = bus.avm_byteenable;
        a.last = w.last;
        wlog.push_back(a);
        m_wc = m_wc < NW ? m_wc + 1 : NW;
        if (int'(w.addr) == NW - 1 && !w.last) m_ovf = 1'b1;
        if (w.last) m_fin = 1'b1;
      end
      if (exp_ready && bus.pix_valid) begin
        if (!have_lo && bus.pix_last) push_word({16'h0, bus.pix_data}, 4'b0011, 1'b1);
        else if (!have_lo) begin
          lo_pix = bus.pix_data;
          have_lo = 1'b1;
        end else begin
          push_word({bus.pix_data, lo_pix}, 4'b1111, bus.pix_last);
          have_lo = 1'b0;
        end
        if (bus.pix_last) m_ended = 1'b1;
      end
      if (w_start) begin
        m_busy = 1'b1;
        m_ended = 1'b0;
        m_addr = 0;
        m_wc = 0;
        m_ovf = 1'b0;
        have_lo = 1'b0;
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (wr_rand) bus.avm_waitrequest = $urandom_range(0, 2) == 0;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send_pix(input logic [15:0] d, input logic l);
    int n = 0;
    logic ok = 1'b0;
    bus.pix_data = d;
    bus.pix_last = l;
    bus.pix_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.pix_ready;
      tick();
      n++;
    end
    bus.pix_valid = 1'b0;
    bus.pix_last = 1'b0;
    chk("pixel_accept_timeout", 32'(ok), 32'h1);
  endtask
  task automatic wait_done(input logic fin_start);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    chk("done_timeout", 32'(seen), 32'h1);
    if (fin_start) begin
      #1 start = 1'b1;
      tick();
      start = 1'b0;
    end else tick();
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_pix_ready"}, 32'(bus.pix_ready), 32'h0);
    chk({tag, "_address"}, 32'(bus.avm_address), 32'h0);
    chk({tag, "_byteenable"}, 32'(bus.avm_byteenable), 32'h0);
    chk({tag, "_chipselect"}, 32'(bus.avm_chipselect), 32'h0);
    chk({tag, "_write"}, 32'(bus.avm_write), 32'h0);
    chk({tag, "_writedata"}, bus.avm_writedata, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_overflow"}, 32'(overflow), 32'h0);
    chk({tag, "_word_count"}, 32'(word_count), 32'h0);
  endtask
  initial begin
    int len;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    bus.pix_last = 1'b0;
    bus.avm_waitrequest = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    reset = 1'b0;
    bus.pix_valid = 1'b1;
    repeat (3) tick();
    chk("idle_pix_ready", 32'(bus.pix_ready), 32'h0);
    bus.pix_valid = 1'b0;
    // four pixels, two full words
    wlog.delete();
    pulse_start();
    send_pix(16'h1111, 1'b0);
    send_pix(16'h2222, 1'b0);
    pulse_start();
    send_pix(16'h3333, 1'b0);
    send_pix(16'h4444, 1'b1);
    wait_done(1'b0);
    chk("four_pix_writes", wlog.size(), 32'd2);
    chk("four_pix_w0", {log_at(0).be, 28'(log_at(0).addr)}, 32'hF000_0000);
    chk("four_pix_d0", log_at(0).data, 32'h2222_1111);
    chk("four_pix_w1", {log_at(1).be, 28'(log_at(1).addr)}, 32'hF000_0001);
    chk("four_pix_d1", log_at(1).data, 32'h4444_3333);
    chk("four_pix_count", 32'(word_count), 32'd2);
    chk("four_pix_busy", 32'(busy), 32'h0);
    // odd pixel count ends in a half word
    wlog.delete();
    pulse_start();
    send_pix(16'haaaa, 1'b0);
    send_pix(16'hbbbb, 1'b0);
    send_pix(16'hcccc, 1'b1);
    wait_done(1'b1);
    chk("half_addr", 32'(log_at(1).addr), 32'd1);
    chk("half_be", 32'(log_at(1).be), 32'h3);
    chk("half_data", 32'(log_at(1).data[15:0]), 32'h0000_cccc);
    chk("half_busy_after_fin_start", 32'(busy), 32'h0);
    // stalled first write
    wlog.delete();
    bus.avm_waitrequest = 1'b1;
    pulse_start();
    send_pix(16'h0123, 1'b0);
    send_pix(16'h4567, 1'b0);
    repeat (5) tick();
    chk("stall_write", 32'(bus.avm_write), 32'h1);
    chk("stall_ready", 32'(bus.pix_ready), 32'h0);
    chk("stall_no_completion", wlog.size(), 32'd0);
    bus.avm_waitrequest = 1'b0;
    send_pix(16'h89ab, 1'b0);
    send_pix(16'hcdef, 1'b1);
    wait_done(1'b0);
    chk("stall_writes", wlog.size(), 32'd2);
    chk("stall_d0", log_at(0).data, 32'h4567_0123);
    // ten pixels overrun a four-word buffer
    wlog.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) send_pix(16'(i + 1), i == 9);
    wait_done(1'b0);
    chk("wrap_writes", wlog.size(), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("wrap_addr%0d", i), 32'(log_at(i).addr), i % 4);
    chk("wrap_d4", log_at(4).data, 32'h000a_0009);
    chk("wrap_overflow", 32'(overflow), 32'h1);
    chk("wrap_count", 32'(word_count), 32'd4);
    // reset during a stalled write
    bus.avm_waitrequest = 1'b1;
    pulse_start();
    send_pix(16'h5555, 1'b0);
    send_pix(16'h6666, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_zero("midwrite_reset");
    tick();
    reset = 1'b0;
    bus.avm_waitrequest = 1'b0;
    wlog.delete();
    pulse_start();
    send_pix(16'h7777, 1'b0);
    send_pix(16'h8888, 1'b1);
    wait_done(1'b0);
    chk("after_reset_addr", 32'(log_at(0).addr), 32'd0);
    chk("after_reset_count", 32'(word_count), 32'd1);
    // random frames, random stalls, stray starts
    wr_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 11);
      pulse_start();
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 7) == 0) pulse_start();
        send_pix(16'($urandom), i == len - 1);
      end
      wait_done(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end
    wr_rand = 1'b0;
    bus.avm_waitrequest = 1'b0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
